// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file access controller: default
// geometry and the controller state encoding.
package regfile_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    // ST_CLR is only reachable when the clear-on-reset sweep is built in.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_RSP  = 3'd3,
        ST_CLR  = 3'd4
    } state_t;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Command-driven initiator for the register file. Accepts one read/write
// command at a time over a valid/ready stream, drives the register-file
// write port and one read port, and returns read data on a response stream.
// Only one access is in flight, so a read always sees all earlier writes.
//
// Build option: define REGFILE_CLEAR_EN to make reset zero every register
// with an ascending sweep before the first command is accepted.
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t state;

    // Controller FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef REGFILE_CLEAR_EN
            state <= ST_CLR;
`else
            state <= ST_IDLE;
`endif
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_addr      <= '0;
            rf_we         <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
            rf_read_addr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            rf_we         <= 1'b1;
                            rf_write_addr <= cmd_addr;
                            rf_write_data <= cmd_wdata;
                            state         <= ST_WR;
                        end else begin
                            rf_read_addr <= cmd_addr;
                            state        <= ST_RD;
                        end
                    end else begin
                        // Also raises ready on the first cycle out of reset.
                        cmd_ready <= 1'b1;
                    end
                end
                ST_WR: begin
                    // Write lands at this edge; write address/data are held.
                    rf_we     <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                ST_RD: begin
                    rsp_data  <= rf_read_data;
                    rsp_addr  <= rf_read_addr;
                    rsp_valid <= 1'b1;
                    state     <= ST_RSP;
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
`ifdef REGFILE_CLEAR_EN
                ST_CLR: begin
                    // rf_write_addr doubles as the sweep counter, starting at 0.
                    rf_write_data <= '0;
                    if (!rf_we) begin
                        rf_we <= 1'b1;
                    end else if (rf_write_addr == LAST_ADDR) begin
                        rf_we     <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        rf_write_addr <= ADDR_W'(rf_write_addr + 1'b1);
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
